// File: rtl/numeric_display_driver.sv
// numeric_display_driver
//   Scans a 4-digit hex value onto a KW4-56NCWB-P-Y seven-segment display.
//   Each digit owns a slot of C_SCAN_DIV cycles. The first C_BLANK_CYCLES
//   cycles of a slot keep every common off (anti-ghosting), and the rest
//   light that digit. New values land in a pending buffer and are promoted
//   to the active set only at a frame boundary, or at once while disabled,
//   so a frame never mixes two values.
//
// Ports
//   CLK, RST     : clock (board CLK_10MHz), async active-high reset
//   ENABLE       : 1 = scan, 0 = dark
//   LZ_EN        : leading-zero suppression on digits 3..1
//   WR_VALID/READY/DATA/DP/COLON : write handshake into the pending buffer
//   PINS[6:0]    : segments a..g, PINS[7] dp (active-high)
//   PINS[11:8]   : digit commons 0..3 (active-low)
//   PINS[13:12]  : colon indicators (active-high)
//   FRAME_DONE   : one-cycle pulse after the digit-3 slot ends

// Per-digit hex-to-segment decoder (gfedcba), with a forced-blank input
// for leading-zero suppression.
module ndd_seg_decode (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        if (!blank) begin
            case (nib)
                4'h0: seg = 7'h3F;
                4'h1: seg = 7'h06;
                4'h2: seg = 7'h5B;
                4'h3: seg = 7'h4F;
                4'h4: seg = 7'h66;
                4'h5: seg = 7'h6D;
                4'h6: seg = 7'h7D;
                4'h7: seg = 7'h07;
                4'h8: seg = 7'h7F;
                4'h9: seg = 7'h6F;
                4'hA: seg = 7'h77;
                4'hB: seg = 7'h7C;
                4'hC: seg = 7'h39;
                4'hD: seg = 7'h5E;
                4'hE: seg = 7'h79;
                default: seg = 7'h71;
            endcase
        end
    end
endmodule

module numeric_display_driver #(
    parameter int C_SCAN_DIV     = 2500,
    parameter int C_BLANK_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        LZ_EN,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [15:0] WR_DATA,
    input  logic [3:0]  WR_DP,
    input  logic [1:0]  WR_COLON,
    output logic [13:0] PINS,
    output logic        FRAME_DONE
);
    localparam int NUM_DIGITS = 4;
    localparam int CW = (C_SCAN_DIV > 1) ? $clog2(C_SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(C_SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(C_BLANK_CYCLES - 1);
    localparam logic [13:0]   PINS_DARK  = 14'b00_1111_0000_0000;

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]  dig, dig_n;

    logic [15:0] act_data, act_data_n, pend_data;
    logic [3:0]  act_dp, act_dp_n, pend_dp;
    logic [1:0]  act_colon, act_colon_n, pend_colon;
    logic        pend;

    logic        accept, frame_end, xfer;
    logic [13:0] pins_n;

    logic [NUM_DIGITS-1:0][6:0] seg_dig;
    logic [NUM_DIGITS-1:0]      zero_hi;   // nibbles 3..k all zero
    logic [NUM_DIGITS-1:0]      lz_blank;

    assign accept    = WR_VALID && WR_READY;
    // Dropping ENABLE discards the partial frame, so no pulse then.
    assign frame_end = ENABLE && (state == S_SHOW) && (cnt == CNT_LAST) && (dig == 2'd3);
    assign xfer      = pend && (frame_end || (state == S_OFF));

    assign act_data_n  = xfer ? pend_data  : act_data;
    assign act_dp_n    = xfer ? pend_dp    : act_dp;
    assign act_colon_n = xfer ? pend_colon : act_colon;

    // Leading-zero chain runs from the most significant nibble downward.
    genvar k;
    generate
        for (k = NUM_DIGITS - 1; k >= 0; k--) begin : g_dig
            if (k == NUM_DIGITS - 1) begin : g_top
                assign zero_hi[k] = (act_data_n[4*k +: 4] == 4'h0);
            end else begin : g_low
                assign zero_hi[k] = zero_hi[k+1] && (act_data_n[4*k +: 4] == 4'h0);
            end
            if (k == 0) begin : g_lsd
                assign lz_blank[k] = 1'b0;
            end else begin : g_msd
                assign lz_blank[k] = LZ_EN && zero_hi[k];
            end
            ndd_seg_decode u_dec (
                .nib   (act_data_n[4*k +: 4]),
                .blank (lz_blank[k]),
                .seg   (seg_dig[k])
            );
        end
    endgenerate

    // Next scan position.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dig_n   = dig;
        if (!ENABLE) begin
            state_n = S_OFF;
            cnt_n   = '0;
            dig_n   = 2'd0;
        end else begin
            case (state)
                S_OFF: begin
                    state_n = S_BLANK;
                    cnt_n   = '0;
                    dig_n   = 2'd0;
                end
                S_BLANK: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_n = S_SHOW;
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        dig_n   = dig + 2'd1;
                        state_n = S_BLANK;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Pins are built from the next scan position so the registered output
    // lines up with the state register in the same cycle.
    always_comb begin
        pins_n = PINS_DARK;
        if (state_n != S_OFF) pins_n[13:12] = act_colon_n;
        if (state_n == S_SHOW) begin
            pins_n[11:8] = ~(4'b0001 << dig_n);
            pins_n[7]    = act_dp_n[dig_n];
            pins_n[6:0]  = seg_dig[dig_n];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_OFF;
            cnt        <= '0;
            dig        <= 2'd0;
            act_data   <= '0;
            act_dp     <= '0;
            act_colon  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_colon <= '0;
            pend       <= 1'b0;
            WR_READY   <= 1'b1;
            PINS       <= PINS_DARK;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dig        <= dig_n;
            act_data   <= act_data_n;
            act_dp     <= act_dp_n;
            act_colon  <= act_colon_n;
            PINS       <= pins_n;
            FRAME_DONE <= frame_end;
            if (accept) begin
                pend_data  <= WR_DATA;
                pend_dp    <= WR_DP;
                pend_colon <= WR_COLON;
                pend       <= 1'b1;
            end else if (xfer) begin
                pend <= 1'b0;
            end
            // Built from the old pend so READY stays low on the clearing
            // edge and rises one cycle later.
            WR_READY <= !pend && !accept;
        end
    end
endmodule

// File: tb/tb_numeric_display_driver.sv
module tb_numeric_display_driver;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FRAME = 4 * DIV;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b1;
    logic        LZ_EN = 1'b0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [15:0] WR_DATA = '0;
    logic [3:0]  WR_DP = '0;
    logic [1:0]  WR_COLON = '0;
    logic [13:0] PINS;
    logic        FRAME_DONE;

    int errors = 0;
    int checks = 0;
    logic [FRAME-1:0] rdy_trace;

    numeric_display_driver #(.C_SCAN_DIV(DIV), .C_BLANK_CYCLES(BLK)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .LZ_EN(LZ_EN),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
        .WR_DP(WR_DP), .WR_COLON(WR_COLON), .PINS(PINS), .FRAME_DONE(FRAME_DONE)
    );

    always #50 CLK = ~CLK;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [1:0]      colon;
        logic            lz;
        logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // At most one common may be low in any cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            checks++;
            if ($countones(~PINS[11:8]) > 1) begin
                errors++;
                $display("FAIL one_common: commons=%b at %0t", PINS[11:8], $time);
            end
        end
    end

    // Called on the negedge of the first cycle of a frame; checks every cycle.
    task automatic check_frame(input string nm, input logic [3:0][6:0] seg,
                               input logic [3:0] dp, input logic [1:0] colon,
                               input logic fd0);
        logic [14:0] exp;
        for (int i = 0; i < FRAME; i++) begin
            int d, c;
            if (i > 0) @(negedge CLK);
            d = i / DIV;
            c = i % DIV;
            if (c < BLK) exp = {(i == 0) && fd0, colon, 4'hF, 8'h00};
            else         exp = {1'b0, colon, 4'hF & ~(4'b0001 << d), dp[d], seg[d]};
            rdy_trace[i] = WR_READY;
            chk($sformatf("%s_c%0d", nm, i), {17'd0, FRAME_DONE, PINS}, {17'd0, exp});
        end
    endtask

    // Returns at the first negedge (strictly after the current one) with FRAME_DONE=1.
    task automatic wait_fd(input string nm, output logic rdy_seen);
        int n = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge CLK);
            n++;
            if (!FRAME_DONE && WR_READY) rdy_seen = 1'b1;
        end while (!FRAME_DONE && n < 200);
        chk({nm, "_fd_seen"}, {31'd0, FRAME_DONE}, 32'd1);
    endtask

    task automatic do_write(input string nm, input logic [15:0] d,
                            input logic [3:0] p, input logic [1:0] c);
        int n = 0;
        while (!WR_READY && n < 200) begin @(negedge CLK); n++; end
        chk({nm, "_ready_wait"}, {31'd0, WR_READY}, 32'd1);
        WR_DATA = d; WR_DP = p; WR_COLON = c; WR_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        WR_VALID = 1'b0;
        chk({nm, "_ready_drop"}, {31'd0, WR_READY}, 32'd0);
    endtask

    vec_t vecs[6];
    logic rs;
    int   n;

    initial begin
        vecs[0] = '{16'h0000, 4'b0000, 2'b00, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[1] = '{16'h00F0, 4'b0000, 2'b00, 1'b1, {7'h00, 7'h00, 7'h71, 7'h3F}};
        vecs[2] = '{16'h8888, 4'b0100, 2'b11, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[3] = '{16'h0500, 4'b0000, 2'b00, 1'b1, {7'h00, 7'h6D, 7'h3F, 7'h3F}};
        vecs[4] = '{16'h9ABF, 4'b1001, 2'b01, 1'b0, {7'h6F, 7'h77, 7'h7C, 7'h71}};
        vecs[5] = '{16'h0007, 4'b0000, 2'b00, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h07}};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_pins", {18'd0, PINS}, 32'h0F00);
        chk("rst_fd", {31'd0, FRAME_DONE}, 32'd0);
        chk("rst_ready", {31'd0, WR_READY}, 32'd1);

        // First frame after reset: write 0x1234, FRAME_DONE 32 cycles on.
        RST = 1'b0; WR_DATA = 16'h1234; WR_VALID = 1'b1;
        @(posedge CLK);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                WR_VALID = 1'b0;
                chk("w1234_ready_drop", {31'd0, WR_READY}, 32'd0);
            end
        end while (!FRAME_DONE && n < 200);
        chk("first_fd_cycle", n, 33);
        check_frame("f1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 2'b00, 1'b1);

        // Table-driven values
        for (int v = 0; v < 6; v++) begin
            LZ_EN = vecs[v].lz;
            do_write($sformatf("v%0d", v), vecs[v].data, vecs[v].dp, vecs[v].colon);
            wait_fd($sformatf("v%0d", v), rs);
            check_frame($sformatf("v%0d", v), vecs[v].seg, vecs[v].dp, vecs[v].colon, 1'b1);
        end

        // Back-to-back offers: 0xAAAA then 0x5555 held.
        LZ_EN = 1'b0;
        do_write("wA", 16'hAAAA, 4'b0000, 2'b00);
        WR_DATA = 16'h5555; WR_VALID = 1'b1;
        wait_fd("wA", rs);
        chk("wA_ready_low_until_fd", {31'd0, rs}, 32'd0);
        check_frame("fA", {4{7'h77}}, 4'b0000, 2'b00, 1'b1);
        chk("wA_ready_trace", {29'd0, rdy_trace[2:0]}, 32'b010);
        WR_VALID = 1'b0;
        wait_fd("w5", rs);
        check_frame("f5", {4{7'h6D}}, 4'b0000, 2'b00, 1'b1);

        // ENABLE drop in digit-2 slot, write while dark, then resume.
        wait_fd("en", rs);
        repeat (20) @(negedge CLK);
        chk("en_pre_drop_common", {28'd0, PINS[11:8]}, 32'b1011);
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("en_dark_pins", {18'd0, PINS}, 32'h0F00);
        chk("en_dark_fd", {31'd0, FRAME_DONE}, 32'd0);
        do_write("wC", 16'hC0DE, 4'b0000, 2'b00);
        rs = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (FRAME_DONE || PINS !== 14'h0F00) rs = 1'b1;
        end
        chk("en_dark_hold", {31'd0, rs}, 32'd0);
        ENABLE = 1'b1;
        @(negedge CLK);
        check_frame("fC", {7'h39, 7'h3F, 7'h5E, 7'h79}, 4'b0000, 2'b00, 1'b0);
        @(negedge CLK);
        chk("fC_end_fd", {31'd0, FRAME_DONE}, 32'd1);

        // Asynchronous reset mid-SHOW.
        repeat (4) @(negedge CLK);
        chk("pre_rst_common", {28'd0, PINS[11:8]}, 32'b1110);
        RST = 1'b1;
        #1;
        chk("async_rst_pins", {18'd0, PINS}, 32'h0F00);
        chk("async_rst_ready", {31'd0, WR_READY}, 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_frame("frst", {4{7'h3F}}, 4'b0000, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
